// File: rtl/sns_pkg.sv
// Shared types and constants for the nibble-serial SubBytes stage of the small-scale AES datapath.
// AFF_MATRIX is row-packed: bits [4j+3:4j] select the inputs XORed into output bit j.
package sns_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] AFF_MATRIX = 16'hBDE7;
  localparam logic [3:0]  AFF_CONST  = 4'h6;

  // Golden 4-bit S-box, nibble i holds SBOX4[i].
  localparam logic [63:0] SBOX4_TBL = 64'h8013_CFD9_A7E2_45B6;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = SBOX4_TBL;
    return tbl[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sns_affine4.sv
// S-box affine output map y = L*x ^ c over GF(2); purely combinational, zero latency.
// No flow control: the caller decides when the result is used.
module sns_affine4
  import sns_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  for (genvar j = 0; j < 4; j++) begin : g_row
    assign y[j] = (^(AFF_MATRIX[4*j +: 4] & x)) ^ AFF_CONST[j];
  end

endmodule

// File: rtl/sub_nibbles_serial.sv
// Nibble-serial SubBytes: one nibble per cycle through the external GF(2^4) inverter, then the affine map.
// Input-to-output handshake latency NUM_NIB+1 (2*NUM_NIB+1 with SNS_INV_REG_EN); out_ready=0 holds DONE.
module sub_nibbles_serial
  import sns_pkg::*;
#(
  parameter int NIB_W     = 4,
  parameter int NUM_NIB   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NUM_NIB-1:0] in_data,
  output logic [NIB_W-1:0]         sbox_in,
  input  logic [NIB_W-1:0]         sbox_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NUM_NIB-1:0] out_data,
  output logic                     busy
);

  localparam int               CNT_W = $clog2(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_NIB - 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         pos;
  logic [NIB_W*NUM_NIB-1:0] word_q;
  logic [NIB_W*NUM_NIB-1:0] res_q;
  logic                     nib_step;
  logic [NIB_W-1:0]         aff_in;
  logic [NIB_W-1:0]         aff_out;

  // The counter parks on LAST after a word, so sbox_in keeps showing the last nibble outside RUN.
  assign pos     = (MSB_FIRST != 0) ? (LAST - cnt_q) : cnt_q;
  assign sbox_in = word_q[pos*NIB_W +: NIB_W];

`ifdef SNS_INV_REG_EN
  logic             phase_q;
  logic [NIB_W-1:0] inv_q;

  // Phase 0 drives the inverter, phase 1 uses the registered return.
  assign nib_step = (state_q == RUN) && phase_q;
  assign aff_in   = inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      inv_q   <= '0;
    end else begin
      phase_q <= (state_q == RUN) ? ~phase_q : 1'b0;
      if ((state_q == RUN) && !phase_q) inv_q <= sbox_out;
    end
  end
`else
  assign nib_step = (state_q == RUN);
  assign aff_in   = sbox_out;
`endif

  sns_affine4 u_affine (
    .x (aff_in),
    .y (aff_out)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (nib_step && (cnt_q == LAST)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && in_valid) begin
        word_q <= in_data;
        cnt_q  <= '0;
      end
      if (nib_step) begin
        res_q[pos*NIB_W +: NIB_W] <= aff_out;
        if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_data = res_q;

endmodule
